// File: rtl/decoder38_seq_if.sv
// Code-stream bus for the sequenced 3-to-8 decoder: producer handshake, run
// enable, and the decoded output with status.
interface decoder38_seq_if #(
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             iValid;
  logic [2:0]       iData;
  logic             oReady;
  logic             iEna;
  logic [7:0]       oData;
  logic             oBusy;
  logic [CNT_W-1:0] oCount;

  modport master (
    output iValid, iData, iEna,
    input  oReady, oData, oBusy, oCount
  );

  modport slave (
    input  iValid, iData, iEna,
    output oReady, oData, oBusy, oCount
  );
endinterface

// File: rtl/decoder38_seq.sv
// Sequenced 3-to-8 decoder: queues codes in a small FIFO and shows each one as a
// one-hot word for HOLD_CYCLES enabled cycles, back-to-back while codes remain.
module decoder38_seq #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic           clk,
  input  logic           rst,
  decoder38_seq_if.slave bus
);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = AW + 1;
  localparam int unsigned HW    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  logic [2:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  state_t           r_state;
  logic [HW-1:0]    r_hold;
  logic [7:0]       r_word;

  state_t           w_state_nxt;
  logic [HW-1:0]    w_hold_nxt;
  logic [7:0]       w_word_nxt;
  logic             w_pop;
  logic             w_push;
  logic             w_ready;
  logic [7:0]       w_onehot;

  assign w_ready  = (r_count != CNT_W'(FIFO_DEPTH));
  assign w_push   = bus.iValid && w_ready;
  assign w_onehot = 8'b1 << r_mem[r_rd_ptr];

  // Next-state: pop on entry from IDLE or when a hold expires with codes waiting.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_word_nxt  = r_word;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.iEna && (r_count != '0)) begin
          w_pop       = 1'b1;
          w_word_nxt  = w_onehot;
          w_hold_nxt  = HW'(HOLD_CYCLES - 1);
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.iEna) begin
          if (r_hold != '0) begin
            w_hold_nxt = r_hold - HW'(1);
          end else if (r_count != '0) begin
            w_pop      = 1'b1;
            w_word_nxt = w_onehot;
            w_hold_nxt = HW'(HOLD_CYCLES - 1);
          end else begin
            w_word_nxt  = '0;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_hold  <= '0;
      r_word  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
      r_word  <= w_word_nxt;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave the count alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) r_mem[r_wr_ptr] <= bus.iData;
  end

  assign bus.oReady = w_ready;
  assign bus.oData  = r_word & {8{bus.iEna}};
  assign bus.oBusy  = (r_state == S_HOLD);
  assign bus.oCount = r_count;
endmodule

// File: tb/tb_decoder38_seq.sv
// Bench for decoder38_seq: directed vector table, hand-built burst/full/reset
// sequences, and random traffic against a queue-based reference model.
module tb_decoder38_seq;
  localparam int unsigned HOLD  = 4;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decoder38_seq_if #(.FIFO_DEPTH(DEPTH)) bus ();
  decoder38_seq #(.HOLD_CYCLES(HOLD), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: queue of pending codes, displayed code, enabled cycles shown.
  int q[$];
  bit m_busy;
  int m_cur;
  int m_shown;

  typedef struct {
    bit         r;
    bit         v;
    logic [2:0] d;
    bit         e;
    logic [7:0] xd;
    bit         xb;
    int         xc;
  } vec_t;
  vec_t tbl[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input bit r, input bit v, input logic [2:0] d, input bit e);
    rst = r; bus.iValid = v; bus.iData = d; bus.iEna = e;
  endtask

  task automatic model_edge();
    bit push;
    if (rst) begin
      q.delete(); m_busy = 0; m_cur = 0; m_shown = 0;
      return;
    end
    push = bus.iValid && (q.size() != DEPTH);
    if (!m_busy) begin
      if (bus.iEna && q.size() > 0) begin
        m_cur = q.pop_front(); m_shown = 0; m_busy = 1;
      end
    end else if (bus.iEna) begin
      m_shown++;
      if (m_shown == HOLD) begin
        if (q.size() > 0) begin
          m_cur = q.pop_front(); m_shown = 0;
        end else begin
          m_busy = 0;
        end
      end
    end
    if (push) q.push_back(int'(bus.iData));
  endtask

  task automatic check_model();
    logic [31:0] xd;
    xd = (m_busy && bus.iEna) ? (32'd1 << m_cur) : 32'd0;
    check("m_data",  32'(bus.oData),  xd);
    check("m_busy",  32'(bus.oBusy),  32'(m_busy));
    check("m_count", 32'(bus.oCount), 32'(q.size()));
    check("m_ready", 32'(bus.oReady), 32'(q.size() != DEPTH));
  endtask

  task automatic step(input bit use_model);
    @(posedge clk);
    model_edge();
    #1;
    if (use_model) check_model();
  endtask

  initial begin
    int k;
    int guard;
    bit acc;
    logic [7:0] seen[$];

    // Reset, single code 7, then code 2 with a 3-cycle pause mid-hold.
    tbl[0]  = '{1, 0, 3'd0, 1, 8'h00, 0, 0};
    tbl[1]  = '{1, 0, 3'd0, 1, 8'h00, 0, 0};
    tbl[2]  = '{0, 1, 3'd7, 1, 8'h00, 0, 1};
    tbl[3]  = '{0, 0, 3'd0, 1, 8'h80, 1, 0};
    tbl[4]  = '{0, 0, 3'd0, 1, 8'h80, 1, 0};
    tbl[5]  = '{0, 0, 3'd0, 1, 8'h80, 1, 0};
    tbl[6]  = '{0, 0, 3'd0, 1, 8'h80, 1, 0};
    tbl[7]  = '{0, 0, 3'd0, 1, 8'h00, 0, 0};
    tbl[8]  = '{0, 1, 3'd2, 1, 8'h00, 0, 1};
    tbl[9]  = '{0, 0, 3'd0, 1, 8'h04, 1, 0};
    tbl[10] = '{0, 0, 3'd0, 1, 8'h04, 1, 0};
    tbl[11] = '{0, 0, 3'd0, 0, 8'h00, 1, 0};
    tbl[12] = '{0, 0, 3'd0, 0, 8'h00, 1, 0};
    tbl[13] = '{0, 0, 3'd0, 0, 8'h00, 1, 0};
    tbl[14] = '{0, 0, 3'd0, 1, 8'h04, 1, 0};
    tbl[15] = '{0, 0, 3'd0, 1, 8'h04, 1, 0};
    tbl[16] = '{0, 0, 3'd0, 1, 8'h00, 0, 0};

    set_in(1, 0, 3'd0, 1);
    for (int i = 0; i < 17; i++) begin
      set_in(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].e);
      step(0);
      check($sformatf("tbl%0d_data", i),  32'(bus.oData),  32'(tbl[i].xd));
      check($sformatf("tbl%0d_busy", i),  32'(bus.oBusy),  32'(tbl[i].xb));
      check($sformatf("tbl%0d_count", i), 32'(bus.oCount), 32'(tbl[i].xc));
      check($sformatf("tbl%0d_ready", i), 32'(bus.oReady), 32'(tbl[i].xc != DEPTH));
    end

    // Burst of codes 0..7 with iValid held high.
    set_in(1, 0, 3'd0, 1); step(1);
    k = 0; guard = 0;
    while (k < 8 && guard < 200) begin
      set_in(0, 1, 3'(k), 1);
      acc = bus.oReady;
      step(1);
      if (bus.oData != 8'h00) seen.push_back(bus.oData);
      if (bus.oCount == 3'(DEPTH)) check("burst_rdy_full", 32'(bus.oReady), 32'd0);
      if (acc) k++;
      guard++;
    end
    check("burst_timeout", 32'(k), 32'd8);
    set_in(0, 0, 3'd0, 1);
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (bus.oData != 8'h00) seen.push_back(bus.oData);
    end
    check("burst_len", 32'(seen.size()), 32'(8 * HOLD));
    for (int i = 0; i < seen.size() && i < 8 * HOLD; i++)
      check("burst_word", 32'(seen[i]), 32'd1 << (i / HOLD));

    // Fill the FIFO while paused, then offer code 5 while full.
    set_in(0, 1, 3'd1, 0); step(1);
    set_in(0, 1, 3'd3, 0); step(1);
    set_in(0, 1, 3'd4, 0); step(1);
    set_in(0, 1, 3'd6, 0); step(1);
    for (int i = 0; i < 3; i++) begin
      set_in(0, 1, 3'd5, 0); step(1);
      check("full_count", 32'(bus.oCount), 32'(DEPTH));
      check("full_ready", 32'(bus.oReady), 32'd0);
    end
    guard = 0;
    do begin
      set_in(0, 1, 3'd5, 1);
      acc = bus.oReady;
      step(1);
      guard++;
    end while (!acc && guard < 100);
    check("full_repush", 32'(acc), 32'd1);
    set_in(0, 0, 3'd0, 1);
    for (int i = 0; i < 25; i++) step(1);

    // Reset while the second word of a burst is displayed.
    set_in(0, 1, 3'd1, 1); step(1);
    set_in(0, 1, 3'd2, 1); step(1);
    set_in(0, 1, 3'd3, 1); step(1);
    set_in(0, 0, 3'd0, 1);
    guard = 0;
    while (bus.oData != 8'h04 && guard < 50) begin step(1); guard++; end
    check("rst_mid_reach", 32'(bus.oData), 32'h04);
    set_in(1, 0, 3'd0, 1); step(1);
    check("rst_mid_data",  32'(bus.oData),  32'd0);
    check("rst_mid_count", 32'(bus.oCount), 32'd0);
    check("rst_mid_busy",  32'(bus.oBusy),  32'd0);
    set_in(0, 0, 3'd0, 1);
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("rst_mid_quiet", 32'(bus.oData), 32'd0);
    end

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      set_in(($urandom_range(0, 99) == 0), ($urandom_range(0, 1) == 1),
             3'($urandom_range(0, 7)), ($urandom_range(0, 4) != 0));
      step(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
